act_dma_sched: RTL and testbench

- Sequencing controller for the activation (element-wise) engine in the Vit accelerator.
- Walks the feature map in CH-slice → H → W-chunk order and issues AXI read commands for input tiles. Issues the matching write commands as the datapath finishes each chunk.
- Bounds in-flight chunks with a credit counter and raises done once every write response has returned.
- Sits between the CSR block (config + start) and the AXI master read/write command queues.

---
 rtl/act_sched_pkg.sv | 27 ++
 rtl/act_addr_walker.sv | 89 ++++++++
 rtl/act_dma_sched.sv | 194 +++++++++++++++++++
 tb/tb_act_dma_sched.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/act_sched_pkg.sv
// Shared types and helpers for the activation-engine DMA scheduler.
// Exports the FSM state enum, the command bundle and the chunk-length helper.
package act_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } state_t;

    localparam int CMD_ADDR_W = 32;

    typedef struct packed {
        logic [CMD_ADDR_W-1:0] addr;
        logic [7:0]            len;
    } cmd_t;

    // Beats-1 for a chunk with `rem` pixels left in the line.
    function automatic logic [7:0] chunk_len(
        input logic [31:0] rem,
        input int          mb
    );
        return (rem > 32'(mb)) ? 8'(mb - 1) : 8'(rem - 32'd1);
    endfunction

endpackage

// File: rtl/act_addr_walker.sv
// Walks one feature map in CH-slice -> H -> W-chunk order with adders only.
// Ports: first (load cfg, go to chunk 0), step (advance), cmd (addr/len), last.
module act_addr_walker
    import act_sched_pkg::*;
#(
    parameter int DIM_W     = 16,
    parameter int PIX_BYTES = 32,
    parameter int MAX_BURST = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  first,
    input  logic                  step,
    input  logic [DIM_W-1:0]      win,
    input  logic [DIM_W-1:0]      hin,
    input  logic [DIM_W-1:0]      slices,
    input  logic [CMD_ADDR_W-1:0] base,
    input  logic [CMD_ADDR_W-1:0] surf_step,
    input  logic [CMD_ADDR_W-1:0] line_step,
    output cmd_t                  cmd,
    output logic                  last
);

    localparam logic [CMD_ADDR_W-1:0] CHUNK_B = CMD_ADDR_W'(MAX_BURST * PIX_BYTES);
    localparam logic [DIM_W-1:0]      MB      = DIM_W'(MAX_BURST);
    localparam logic [DIM_W-1:0]      ONE     = DIM_W'(1);

    logic [DIM_W-1:0]      win_q, hin_q, sl_q;
    logic [DIM_W-1:0]      c_q, h_q, rem_q;
    logic [CMD_ADDR_W-1:0] surf_q, line_q;
    logic [CMD_ADDR_W-1:0] sbase_q, lbase_q;
    logic                  line_end, h_last, c_last;

    // rem_q counts pixels still to issue in the current line.
    assign line_end = (rem_q <= MB);
    assign h_last   = (h_q == hin_q - ONE);
    assign c_last   = (c_q == sl_q - ONE);
    assign last     = line_end && h_last && c_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q   <= '0;
            hin_q   <= '0;
            sl_q    <= '0;
            surf_q  <= '0;
            line_q  <= '0;
            c_q     <= '0;
            h_q     <= '0;
            rem_q   <= '0;
            sbase_q <= '0;
            lbase_q <= '0;
            cmd     <= '0;
        end else if (first) begin
            win_q    <= win;
            hin_q    <= hin;
            sl_q     <= slices;
            surf_q   <= surf_step;
            line_q   <= line_step;
            c_q      <= '0;
            h_q      <= '0;
            rem_q    <= win;
            sbase_q  <= base;
            lbase_q  <= base;
            cmd.addr <= base;
            cmd.len  <= chunk_len(32'(win), MAX_BURST);
        end else if (step) begin
            if (!line_end) begin
                rem_q    <= rem_q - MB;
                cmd.addr <= cmd.addr + CHUNK_B;
                cmd.len  <= chunk_len(32'(rem_q - MB), MAX_BURST);
            end else begin
                rem_q   <= win_q;
                cmd.len <= chunk_len(32'(win_q), MAX_BURST);
                if (!h_last) begin
                    h_q      <= h_q + ONE;
                    lbase_q  <= lbase_q + line_q;
                    cmd.addr <= lbase_q + line_q;
                end else begin
                    h_q      <= '0;
                    c_q      <= c_q + ONE;
                    sbase_q  <= sbase_q + surf_q;
                    lbase_q  <= sbase_q + surf_q;
                    cmd.addr <= sbase_q + surf_q;
                end
            end
        end
    end

endmodule

// File: rtl/act_dma_sched.sv
// Activation-engine DMA scheduler: issues tile read/write commands with credits.
// Ports: CSR cfg+start, rd/wr command handshakes, res_avail, wr_resp, busy, done.
// Optional ACT_SCHED_PERF_EN adds perf_busy_cyc / perf_stall_cyc counters.
module act_dma_sched
    import act_sched_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DIM_W           = 16,
    parameter int PIX_BYTES       = 32,
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_win,
    input  logic [DIM_W-1:0]  cfg_hin,
    input  logic [DIM_W-1:0]  cfg_ch_slices,
    input  logic [ADDR_W-1:0] cfg_in_base,
    input  logic [ADDR_W-1:0] cfg_in_surf,
    input  logic [ADDR_W-1:0] cfg_in_line,
    input  logic [ADDR_W-1:0] cfg_out_base,
    input  logic [ADDR_W-1:0] cfg_out_surf,
    input  logic [ADDR_W-1:0] cfg_out_line,
    output logic              rd_cmd_valid,
    input  logic              rd_cmd_ready,
    output logic [ADDR_W-1:0] rd_cmd_addr,
    output logic [7:0]        rd_cmd_len,
    output logic              wr_cmd_valid,
    input  logic              wr_cmd_ready,
    output logic [ADDR_W-1:0] wr_cmd_addr,
    output logic [7:0]        wr_cmd_len,
    input  logic              res_avail,
    input  logic              wr_resp,
    output logic              busy,
    output logic              done
`ifdef ACT_SCHED_PERF_EN
    ,
    output logic [31:0]       perf_busy_cyc,
    output logic [31:0]       perf_stall_cyc
`endif
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_OS = CW'(MAX_OUTSTANDING);

    state_t        state;
    logic [CW-1:0] infl, pend, infl_nxt, pend_nxt;
    logic [31:0]   rd_cnt, resp_cnt;
    logic          wr_done, wr_done_nxt;
    logic          rd_hs, wr_hs, launch, zero_dim, active;
    cmd_t          rd_cmd, wr_cmd;
    logic          rd_last, wr_last;

    assign rd_hs    = rd_cmd_valid && rd_cmd_ready;
    assign wr_hs    = wr_cmd_valid && wr_cmd_ready;
    assign launch   = (state == IDLE) && start;
    assign zero_dim = (cfg_win == '0) || (cfg_hin == '0) || (cfg_ch_slices == '0);
    assign active   = (state == RUN) || (state == DRAIN);

    // infl = chunks read but not yet written; pend = results waiting for a write.
    assign infl_nxt    = infl + CW'(rd_hs) - CW'(wr_hs);
    assign pend_nxt    = pend + CW'(res_avail) - CW'(wr_hs);
    assign wr_done_nxt = wr_done || (wr_hs && wr_last);

    assign rd_cmd_addr = ADDR_W'(rd_cmd.addr);
    assign rd_cmd_len  = rd_cmd.len;
    assign wr_cmd_addr = ADDR_W'(wr_cmd.addr);
    assign wr_cmd_len  = wr_cmd.len;

    act_addr_walker #(
        .DIM_W     (DIM_W),
        .PIX_BYTES (PIX_BYTES),
        .MAX_BURST (MAX_BURST)
    ) u_rd_walk (
        .clk       (clk),
        .rst_n     (rst_n),
        .first     (launch),
        .step      (rd_hs),
        .win       (cfg_win),
        .hin       (cfg_hin),
        .slices    (cfg_ch_slices),
        .base      (CMD_ADDR_W'(cfg_in_base)),
        .surf_step (CMD_ADDR_W'(cfg_in_surf)),
        .line_step (CMD_ADDR_W'(cfg_in_line)),
        .cmd       (rd_cmd),
        .last      (rd_last)
    );

    act_addr_walker #(
        .DIM_W     (DIM_W),
        .PIX_BYTES (PIX_BYTES),
        .MAX_BURST (MAX_BURST)
    ) u_wr_walk (
        .clk       (clk),
        .rst_n     (rst_n),
        .first     (launch),
        .step      (wr_hs),
        .win       (cfg_win),
        .hin       (cfg_hin),
        .slices    (cfg_ch_slices),
        .base      (CMD_ADDR_W'(cfg_out_base)),
        .surf_step (CMD_ADDR_W'(cfg_out_surf)),
        .line_step (CMD_ADDR_W'(cfg_out_line)),
        .cmd       (wr_cmd),
        .last      (wr_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            rd_cmd_valid <= 1'b0;
            wr_cmd_valid <= 1'b0;
            infl         <= '0;
            pend         <= '0;
            rd_cnt       <= '0;
            resp_cnt     <= '0;
            wr_done      <= 1'b0;
        end else begin
            if (active) begin
                infl     <= infl_nxt;
                pend     <= pend_nxt;
                rd_cnt   <= rd_cnt + 32'(rd_hs);
                resp_cnt <= resp_cnt + 32'(wr_resp);
                wr_done  <= wr_done_nxt;
            end
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy     <= 1'b1;
                        infl     <= '0;
                        pend     <= '0;
                        rd_cnt   <= '0;
                        resp_cnt <= '0;
                        wr_done  <= 1'b0;
                        state    <= zero_dim ? FIN : RUN;
                    end
                end
                RUN: begin
                    wr_cmd_valid <= (pend_nxt != '0) && !wr_done_nxt;
                    if (rd_hs && rd_last) begin
                        rd_cmd_valid <= 1'b0;
                        state        <= DRAIN;
                    end else begin
                        rd_cmd_valid <= (infl_nxt < MAX_OS);
                    end
                end
                DRAIN: begin
                    rd_cmd_valid <= 1'b0;
                    // rd_cnt is final here, so it is the job's chunk total.
                    if (resp_cnt == rd_cnt) begin
                        wr_cmd_valid <= 1'b0;
                        state        <= FIN;
                    end else begin
                        wr_cmd_valid <= (pend_nxt != '0) && !wr_done_nxt;
                    end
                end
                FIN: begin
                    done         <= 1'b1;
                    busy         <= 1'b0;
                    rd_cmd_valid <= 1'b0;
                    wr_cmd_valid <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

`ifdef ACT_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy_cyc  <= '0;
            perf_stall_cyc <= '0;
        end else if (launch) begin
            perf_busy_cyc  <= '0;
            perf_stall_cyc <= '0;
        end else if (busy) begin
            perf_busy_cyc <= perf_busy_cyc + 32'd1;
            if ((rd_cmd_valid && !rd_cmd_ready) ||
                (state == RUN && !rd_cmd_valid && infl >= MAX_OS))
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
        end
    end
`endif

    a_res_overflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(active && res_avail && pend == MAX_OS)
    ) else $error("res_avail with result buffer full");

endmodule

// File: tb/tb_act_dma_sched.sv
// Randomized self-checking bench for act_dma_sched against a loop-nest model.
// Drives/samples on the falling edge; DUT acts on the rising edge.
module tb_act_dma_sched;

    localparam int MB = 16;
    localparam int PB = 32;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [15:0] cfg_win, cfg_hin, cfg_ch_slices;
    logic [31:0] cfg_in_base, cfg_in_surf, cfg_in_line;
    logic [31:0] cfg_out_base, cfg_out_surf, cfg_out_line;
    logic        rd_cmd_valid, rd_cmd_ready;
    logic [31:0] rd_cmd_addr;
    logic [7:0]  rd_cmd_len;
    logic        wr_cmd_valid, wr_cmd_ready;
    logic [31:0] wr_cmd_addr;
    logic [7:0]  wr_cmd_len;
    logic        res_avail, wr_resp, busy, done;
`ifdef ACT_SCHED_PERF_EN
    logic [31:0] perf_busy_cyc, perf_stall_cyc;
`endif

    always #5 clk = ~clk;

    act_dma_sched #(
        .ADDR_W(32), .DIM_W(16), .PIX_BYTES(PB),
        .MAX_BURST(MB), .MAX_OUTSTANDING(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_win(cfg_win), .cfg_hin(cfg_hin), .cfg_ch_slices(cfg_ch_slices),
        .cfg_in_base(cfg_in_base), .cfg_in_surf(cfg_in_surf),
        .cfg_in_line(cfg_in_line), .cfg_out_base(cfg_out_base),
        .cfg_out_surf(cfg_out_surf), .cfg_out_line(cfg_out_line),
        .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
        .rd_cmd_addr(rd_cmd_addr), .rd_cmd_len(rd_cmd_len),
        .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
        .wr_cmd_addr(wr_cmd_addr), .wr_cmd_len(wr_cmd_len),
        .res_avail(res_avail), .wr_resp(wr_resp),
        .busy(busy), .done(done)
`ifdef ACT_SCHED_PERF_EN
        , .perf_busy_cyc(perf_busy_cyc), .perf_stall_cyc(perf_stall_cyc)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [39:0] exp_rd[$], exp_wr[$], act_rd[$], act_wr[$];
    int res_q[$], resp_q[$];
    int cyc = 0, s_cyc, first_v, done_cyc, last_resp, resp_at_done;
    int rd_n, wr_n, resp_n, done_n, busy_n;
    int rdy_mode = 0;
    bit wr_rand = 0, res_en = 1, hold_pend = 0;
    logic [39:0] hold_val;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        int t;
        @(negedge clk);
        cyc++;
        case (rdy_mode)
            1:       rd_cmd_ready = ($urandom_range(0, 3) != 0);
            2:       rd_cmd_ready = 1'b0;
            default: rd_cmd_ready = 1'b1;
        endcase
        wr_cmd_ready = wr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (hold_pend)
            chk("rd_hold", {rd_cmd_valid, rd_cmd_addr, rd_cmd_len},
                {1'b1, hold_val});
        hold_pend = rd_cmd_valid && !rd_cmd_ready;
        hold_val  = {rd_cmd_addr, rd_cmd_len};
        if (rd_cmd_valid && first_v < 0) first_v = cyc;
        if (rd_cmd_valid && rd_cmd_ready) begin
            if (rd_n < exp_rd.size())
                chk("rd_cmd", {rd_cmd_addr, rd_cmd_len}, exp_rd[rd_n]);
            else
                chk("rd_extra", rd_n, exp_rd.size());
            act_rd.push_back({rd_cmd_addr, rd_cmd_len});
            rd_n++;
            if (res_en) begin
                t = cyc + 3;
                if (res_q.size() > 0 && t <= res_q[$]) t = res_q[$] + 1;
                res_q.push_back(t);
            end
        end
        if (wr_cmd_valid && wr_cmd_ready) begin
            if (wr_n < exp_wr.size())
                chk("wr_cmd", {wr_cmd_addr, wr_cmd_len}, exp_wr[wr_n]);
            else
                chk("wr_extra", wr_n, exp_wr.size());
            act_wr.push_back({wr_cmd_addr, wr_cmd_len});
            wr_n++;
            t = cyc + $urandom_range(1, 4);
            if (resp_q.size() > 0 && t <= resp_q[$]) t = resp_q[$] + 1;
            resp_q.push_back(t);
        end
        res_avail = 1'b0;
        if (res_q.size() > 0 && res_q[0] <= cyc) begin
            res_avail = 1'b1;
            void'(res_q.pop_front());
        end
        wr_resp = 1'b0;
        if (resp_q.size() > 0 && resp_q[0] <= cyc) begin
            wr_resp = 1'b1;
            void'(resp_q.pop_front());
            resp_n++;
            last_resp = cyc;
        end
        if (done) begin
            done_n++;
            done_cyc = cyc;
            resp_at_done = resp_n;
            chk("done_busy", busy, 0);
        end
        if (busy) busy_n++;
    endtask

    task automatic start_job(input int w, input int h, input int sl,
                             input logic [31:0] ib, input logic [31:0] is,
                             input logic [31:0] il, input logic [31:0] ob,
                             input logic [31:0] os, input logic [31:0] ol);
        int n;
        exp_rd.delete(); exp_wr.delete(); act_rd.delete(); act_wr.delete();
        for (int c = 0; c < sl; c++)
            for (int y = 0; y < h; y++)
                for (int x = 0; x < w; x += MB) begin
                    n = (w - x > MB) ? MB : w - x;
                    exp_rd.push_back({ib + is * 32'(c) + il * 32'(y) +
                                      32'(x * PB), 8'(n - 1)});
                    exp_wr.push_back({ob + os * 32'(c) + ol * 32'(y) +
                                      32'(x * PB), 8'(n - 1)});
                end
        rd_n = 0; wr_n = 0; resp_n = 0; done_n = 0; busy_n = 0;
        first_v = -1; done_cyc = 0; last_resp = 0; resp_at_done = -1;
        step();
        s_cyc = cyc;
        cfg_win = 16'(w); cfg_hin = 16'(h); cfg_ch_slices = 16'(sl);
        cfg_in_base = ib; cfg_in_surf = is; cfg_in_line = il;
        cfg_out_base = ob; cfg_out_surf = os; cfg_out_line = ol;
        start = 1'b1;
        step();
        start = 1'b0;
        cfg_win = 16'($urandom_range(1, 90));
        cfg_hin = 16'($urandom_range(1, 9));
        cfg_ch_slices = 16'($urandom_range(1, 9));
        cfg_in_base = $urandom; cfg_out_base = $urandom;
    endtask

    task automatic finish_job();
        int total;
        total = exp_rd.size();
        while (done_n == 0 && cyc - s_cyc < 5000) step();
        chk("job_done", done_n, 1);
        repeat (3) step();
        chk("done_once", done_n, 1);
        chk("busy_end", busy, 0);
        chk("rd_count", rd_n, total);
        chk("wr_count", wr_n, total);
        chk("resp_at_done", resp_at_done, total);
        if (total > 0) begin
            chk("first_valid_lat", first_v - s_cyc, 2);
            chk("done_after_resp", done_cyc > last_resp, 1);
        end else begin
            chk("zero_done_lat", done_cyc - s_cyc, 2);
            chk("zero_busy_cyc", busy_n, 1);
            chk("zero_no_rd", first_v, -1);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; res_avail = 1'b0; wr_resp = 1'b0;
        rd_cmd_ready = 1'b1; wr_cmd_ready = 1'b1;
        cfg_win = '0; cfg_hin = '0; cfg_ch_slices = '0;
        cfg_in_base = '0; cfg_in_surf = '0; cfg_in_line = '0;
        cfg_out_base = '0; cfg_out_surf = '0; cfg_out_line = '0;
        first_v = -1;
        repeat (3) step();
        chk("rst_ctrl", {busy, done, rd_cmd_valid, wr_cmd_valid}, 0);
        chk("rst_cmd", {rd_cmd_addr, rd_cmd_len, wr_cmd_addr, wr_cmd_len}, 0);
        rst_n = 1'b1;
        step();

        start_job(197, 1, 6, 32'h0, 32'h18A0, 32'h18A0,
                  32'h200_0000, 32'h18A0, 32'h18A0);
        finish_job();
        chk("a_reads", act_rd.size(), 78);
        chk("a_len_mid", act_rd[11][7:0], 15);
        chk("a_len_tail", act_rd[12][7:0], 4);
        chk("a_slice1_rd", act_rd[13][39:8], 32'h18A0);
        chk("a_first_wr", act_wr[0][39:8], 32'h200_0000);
        chk("a_slice1_wr", act_wr[13][39:8], 32'h200_18A0);

        start_job(16, 2, 2, 32'h1000, 32'h800, 32'h200,
                  32'h9000, 32'h800, 32'h200);
        finish_job();
        start_job(17, 1, 1, 32'h40, 32'h0, 32'h0, 32'h80, 32'h0, 32'h0);
        finish_job();
        start_job(1, 3, 1, 32'h100, 32'h0, 32'h20, 32'h300, 32'h0, 32'h20);
        finish_job();

        start_job(8, 0, 2, 32'h0, 32'h100, 32'h100, 32'h0, 32'h100, 32'h100);
        finish_job();

        res_en = 1'b0;
        start_job(64, 2, 1, 32'h0, 32'h0, 32'h800, 32'h4000, 32'h0, 32'h800);
        repeat (30) step();
        chk("credit_rd4", rd_n, 4);
        chk("credit_hold", rd_cmd_valid, 0);
        res_q.push_back(cyc + 1);
        repeat (20) step();
        chk("credit_rd5", rd_n, 5);
        chk("credit_wr1", wr_n, 1);
        for (int k = 1; k <= 4; k++) res_q.push_back(cyc + k);
        res_en = 1'b1;
        finish_job();

        start_job(80, 2, 2, 32'h10000, 32'h4000, 32'h1000,
                  32'h50000, 32'h4000, 32'h1000);
        while (!rd_cmd_valid && cyc - s_cyc < 20) step();
        step();
        rdy_mode = 2;
        repeat (5) step();
        rdy_mode = 0;
        finish_job();

        start_job(48, 3, 2, 32'h2000, 32'h2000, 32'h600,
                  32'h8000, 32'h2000, 32'h600);
        repeat (10) step();
        cfg_win = 16'd5; cfg_hin = 16'd1; cfg_ch_slices = 16'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        finish_job();

        start_job(100, 4, 3, 32'h0, 32'h10000, 32'h1000,
                  32'h80000, 32'h10000, 32'h1000);
        repeat (15) step();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctrl", {busy, done, rd_cmd_valid, wr_cmd_valid}, 0);
        chk("rst_mid_cmd", {rd_cmd_addr, rd_cmd_len, wr_cmd_addr, wr_cmd_len}, 0);
        res_q.delete(); resp_q.delete(); hold_pend = 0;
        res_avail = 1'b0; wr_resp = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (4) step();
        chk("rst_no_done", done_n, 0);

        rdy_mode = 1;
        wr_rand = 1'b1;
        for (int j = 0; j < 5; j++) begin
            start_job($urandom_range(1, 40), $urandom_range(1, 3),
                      $urandom_range(1, 3), $urandom & ~32'h1F,
                      $urandom & ~32'h1F, $urandom & ~32'h1F,
                      $urandom & ~32'h1F, $urandom & ~32'h1F,
                      $urandom & ~32'h1F);
            finish_job();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
